// File: rtl/out_port_pkg.sv
// Shared constants for the buffered CPU output port: default sizing,
// status-word bit positions and the overflow clear-command value.
package out_port_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    localparam logic [63:0] OVF_CLEAR_CMD = '1;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int stat_empty_ofs(input int depth);
        return count_w(depth);
    endfunction

    function automatic int stat_full_ofs(input int depth);
        return count_w(depth) + 1;
    endfunction

    function automatic int stat_ovf_ofs(input int depth);
        return count_w(depth) + 2;
    endfunction

    localparam int COUNT_W        = count_w(DEFAULT_DEPTH);
    localparam int STAT_COUNT_OFS = 0;
    localparam int STAT_EMPTY_OFS = stat_empty_ofs(DEFAULT_DEPTH);
    localparam int STAT_FULL_OFS  = stat_full_ofs(DEFAULT_DEPTH);
    localparam int STAT_OVF_OFS   = stat_ovf_ofs(DEFAULT_DEPTH);

endpackage

// File: rtl/out_port_buffered_if.sv
// Bus-side and device-side signals of the buffered output port.
// The port itself uses the slave view; the CPU/device model uses the master view.
interface out_port_buffered_if import out_port_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);

    localparam int CW = count_w(DEPTH);

    logic [WIDTH-1:0] BusMux_Out;
    logic             OutPort_In;
    logic [WIDTH-1:0] Ext_Data;
    logic             Ext_Valid;
    logic             Ext_Ready;
    logic [WIDTH-1:0] Last_Out;
    logic [CW-1:0]    Count;
    logic             Full;
    logic             Empty;
    logic             Overflow;
    logic [WIDTH-1:0] Status;

    modport slave (
        input  BusMux_Out,
        input  OutPort_In,
        input  Ext_Ready,
        output Ext_Data,
        output Ext_Valid,
        output Last_Out,
        output Count,
        output Full,
        output Empty,
        output Overflow,
        output Status
    );

    modport master (
        output BusMux_Out,
        output OutPort_In,
        output Ext_Ready,
        input  Ext_Data,
        input  Ext_Valid,
        input  Last_Out,
        input  Count,
        input  Full,
        input  Empty,
        input  Overflow,
        input  Status
    );

endinterface

// File: rtl/out_port_fifo.sv
// DEPTH-entry FIFO behind the output port: storage, wrap-around pointers,
// occupancy count and a registered head view for the external device.
module out_port_fifo import out_port_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      valid,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q;

    assign rd_ptr_nxt = rd_ptr + PW'(1);
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign valid      = ~empty;
    assign count      = count_q;
    assign rd_data    = head_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The head register is what the device sees. When the only entry is popped
    // while a new one arrives, the new value has not reached mem yet, so it is
    // forwarded from wr_data; otherwise the next entry is already stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
        end else if (pop) begin
            if (count_q == CW'(1)) begin
                if (push) begin
                    head_q <= wr_data;
                end
            end else begin
                head_q <= mem[rd_ptr_nxt];
            end
        end else if (push && empty) begin
            head_q <= wr_data;
        end
    end

endmodule

// File: rtl/out_port_buffered.sv
// Buffered CPU output port: captures `out` writes into a FIFO drained over valid/ready.
// Build option OUTPORT_OVF_STICKY_EN makes Overflow sticky with an all-ones clear command.
module out_port_buffered import out_port_pkg::*; #(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int EDGE_STROBE = 1
) (
    input logic                clk,
    input logic                rst,
    out_port_buffered_if.slave port
);

    localparam int CW        = count_w(DEPTH);
    localparam int EMPTY_OFS = stat_empty_ofs(DEPTH);
    localparam int FULL_OFS  = stat_full_ofs(DEPTH);
    localparam int OVF_OFS   = stat_ovf_ofs(DEPTH);
    localparam bit EDGE_MODE = (EDGE_STROBE != 0);

    generate
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("out_port_buffered: DEPTH must be a power of two in 2..16");
        end
        if (WIDTH < CW + 3 || WIDTH > 64) begin : g_bad_width
            $error("out_port_buffered: WIDTH must hold the status word and be at most 64");
        end
    endgenerate

    logic             strobe_q;
    logic             push_req;
    logic             pop;
    logic             clear_cmd;
    logic             push_acc;
    logic             drop;
    logic             ovf_q;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_valid;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] status_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= port.OutPort_In;
        end
    end

    assign push_req = port.OutPort_In & ~(strobe_q & EDGE_MODE);
    assign pop      = fifo_valid & port.Ext_Ready;

    // A clear command carries no data, so it needs no free slot and is never dropped.
`ifdef OUTPORT_OVF_STICKY_EN
    assign clear_cmd = push_req & (port.BusMux_Out == OVF_CLEAR_CMD[WIDTH-1:0]);
`else
    assign clear_cmd = 1'b0;
`endif

    assign push_acc = push_req & ~clear_cmd & (~fifo_full | pop);
    assign drop     = push_req & ~clear_cmd & fifo_full & ~pop;

    out_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_acc),
        .pop     (pop),
        .wr_data (port.BusMux_Out),
        .rd_data (fifo_data),
        .valid   (fifo_valid),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else if (push_acc) begin
            last_q <= port.BusMux_Out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
`ifdef OUTPORT_OVF_STICKY_EN
        end else if (clear_cmd) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
`else
        end else begin
            ovf_q <= drop;
`endif
        end
    end

    always_comb begin
        status_w                = '0;
        status_w[CW-1:0]        = fifo_count;
        status_w[EMPTY_OFS]     = fifo_empty;
        status_w[FULL_OFS]      = fifo_full;
        status_w[OVF_OFS]       = ovf_q;
    end

    assign port.Ext_Data  = fifo_data;
    assign port.Ext_Valid = fifo_valid;
    assign port.Last_Out  = last_q;
    assign port.Count     = fifo_count;
    assign port.Full      = fifo_full;
    assign port.Empty     = fifo_empty;
    assign port.Overflow  = ovf_q;
    assign port.Status    = status_w;

endmodule

// File: tb/tb_out_port_buffered.sv
// Scoreboard bench for out_port_buffered: an edge-strobe instance is fully modelled,
// a level-strobe twin shares the same inputs for the strobe-mode comparison.
module tb_out_port_buffered;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    out_port_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) edge_if ();
    out_port_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) lvl_if ();

    out_port_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EDGE_STROBE(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (edge_if.slave)
    );

    out_port_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EDGE_STROBE(0)) dut_lvl (
        .clk  (clk),
        .rst  (rst),
        .port (lvl_if.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m_q [$];
    logic [31:0] drained [$];
    logic [31:0] m_last;
    logic        m_ovf;
    logic        m_strobe_q;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_last     = '0;
        m_ovf      = 1'b0;
        m_strobe_q = 1'b0;
    endtask

    task automatic driveInputs(input logic oi, input logic [31:0] bus, input logic rdy);
        edge_if.OutPort_In = oi;
        edge_if.BusMux_Out = bus;
        edge_if.Ext_Ready  = rdy;
        lvl_if.OutPort_In  = oi;
        lvl_if.BusMux_Out  = bus;
        lvl_if.Ext_Ready   = rdy;
    endtask

    task automatic compareState();
        logic [31:0] st;
        int          n;
        n      = m_q.size();
        st     = '0;
        st[2:0] = 3'(n);
        st[3]  = (n == 0);
        st[4]  = (n == DEPTH);
        st[5]  = m_ovf;
        checkOutput("count", 32'(edge_if.Count), 32'(n));
        checkOutput("valid", 32'(edge_if.Ext_Valid), 32'(n != 0));
        checkOutput("full", 32'(edge_if.Full), 32'(n == DEPTH));
        checkOutput("empty", 32'(edge_if.Empty), 32'(n == 0));
        checkOutput("last_out", edge_if.Last_Out, m_last);
        checkOutput("overflow", 32'(edge_if.Overflow), 32'(m_ovf));
        checkOutput("status", edge_if.Status, st);
        if (n != 0) begin
            checkOutput("head", edge_if.Ext_Data, m_q[0]);
        end
    endtask

    // Called just after a falling edge: drives one cycle, predicts the rising edge, checks after it.
    task automatic applyStimulus(input logic oi, input logic [31:0] bus, input logic rdy);
        logic        push_req, pop, full, cmd, accept, drop, stall;
        logic [31:0] hold, gone;
        driveInputs(oi, bus, rdy);
        push_req = oi & ~m_strobe_q;
        pop      = (m_q.size() != 0) & rdy;
        full     = (m_q.size() == DEPTH);
        cmd      = 1'b0;
`ifdef OUTPORT_OVF_STICKY_EN
        cmd      = push_req & (bus == 32'hFFFF_FFFF);
`endif
        accept   = push_req & ~cmd & (~full | pop);
        drop     = push_req & ~cmd & full & ~pop;
        stall    = (m_q.size() != 0) & ~rdy;
        hold     = edge_if.Ext_Data;
        if (pop) begin
            checkOutput("pop_data", edge_if.Ext_Data, m_q[0]);
            drained.push_back(edge_if.Ext_Data);
            gone = m_q.pop_front();
        end
        if (accept) begin
            m_q.push_back(bus);
            m_last = bus;
        end
`ifdef OUTPORT_OVF_STICKY_EN
        if (cmd) m_ovf = 1'b0;
        else if (drop) m_ovf = 1'b1;
`else
        m_ovf = drop;
`endif
        m_strobe_q = oi;
        @(posedge clk);
        @(negedge clk);
        if (stall) begin
            checkOutput("stall_hold", edge_if.Ext_Data, hold);
        end
        compareState();
    endtask

    // Asynchronous clear in the middle of a low clock phase, checked before any edge.
    task automatic applyClear();
        @(negedge clk);
        #1;
        driveInputs(1'b0, '0, 1'b0);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("clr_count", 32'(edge_if.Count), 32'd0);
        checkOutput("clr_valid", 32'(edge_if.Ext_Valid), 32'd0);
        checkOutput("clr_data", edge_if.Ext_Data, 32'd0);
        checkOutput("clr_last", edge_if.Last_Out, 32'd0);
        checkOutput("clr_ovf", 32'(edge_if.Overflow), 32'd0);
        checkOutput("clr_empty", 32'(edge_if.Empty), 32'd1);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compareState();
    endtask

    task automatic drainAll(input int budget, input string tag);
        int steps;
        steps = 0;
        while (m_q.size() != 0 && steps < budget) begin
            applyStimulus(1'b0, '0, 1'b1);
            steps++;
        end
        checkOutput(tag, 32'(edge_if.Empty), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_order [4];
        exp_order = '{32'h2, 32'h3, 32'h4, 32'h6};

        rst = 1'b1;
        driveInputs(1'b0, '0, 1'b0);
        modelReset();
        @(negedge clk);
        compareState();
        checkOutput("rst_data", edge_if.Ext_Data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Held strobe: one push on the edge instance, one per cycle on the level twin.
        applyStimulus(1'b1, 32'hB080_0000, 1'b0);
        applyStimulus(1'b1, 32'hB080_0000, 1'b0);
        checkOutput("edge_count", 32'(edge_if.Count), 32'd1);
        checkOutput("edge_data", edge_if.Ext_Data, 32'hB080_0000);
        checkOutput("edge_last", edge_if.Last_Out, 32'hB080_0000);
        checkOutput("lvl_count", 32'(lvl_if.Count), 32'd2);
        checkOutput("lvl_data", lvl_if.Ext_Data, 32'hB080_0000);
        applyClear();

        // Fill to full, then one dropped write.
        for (int v = 1; v <= 4; v++) begin
            applyStimulus(1'b1, 32'(v), 1'b0);
            applyStimulus(1'b0, '0, 1'b0);
        end
        checkOutput("full_status", edge_if.Status, 32'h0000_0014);
        applyStimulus(1'b1, 32'h5, 1'b0);
        checkOutput("drop_ovf", 32'(edge_if.Overflow), 32'd1);
        checkOutput("drop_last", edge_if.Last_Out, 32'h4);
        checkOutput("drop_count", 32'(edge_if.Count), 32'd4);
`ifdef OUTPORT_OVF_STICKY_EN
        repeat (5) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ovf_sticky", 32'(edge_if.Overflow), 32'd1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
        checkOutput("ovf_cleared", 32'(edge_if.Overflow), 32'd0);
        checkOutput("ovf_clr_count", 32'(edge_if.Count), 32'd4);
        applyStimulus(1'b0, '0, 1'b0);
`else
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ovf_pulse_end", 32'(edge_if.Overflow), 32'd0);
`endif

        // Push and pop together while full: the freed slot takes the new value.
        checkOutput("swap_head", edge_if.Ext_Data, 32'h1);
        applyStimulus(1'b1, 32'h6, 1'b1);
        checkOutput("swap_count", 32'(edge_if.Count), 32'd4);
        drained.delete();
        drainAll(8, "drain_full");
        checkOutput("drain_len", 32'(drained.size()), 32'd4);
        for (int i = 0; i < 4 && i < drained.size(); i++) begin
            checkOutput($sformatf("drain_order%0d", i), drained[i], exp_order[i]);
        end

        // Ten writes with a toggling device ready, crossing the pointer wrap.
        drained.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), (i % 2) == 0);
            applyStimulus(1'b0, '0, (i % 2) != 0);
        end
        drainAll(20, "drain_wrap");
        checkOutput("wrap_len", 32'(drained.size()), 32'd10);
        if (drained.size() == 10) begin
            checkOutput("wrap_last", drained[9], 32'h109);
        end

        // Clear with two entries queued; the next write must be the first one out.
        applyStimulus(1'b1, 32'hA, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pre_clear_count", 32'(edge_if.Count), 32'd2);
        applyClear();
        drained.delete();
        applyStimulus(1'b1, 32'h5, 1'b0);
        checkOutput("post_clear_head", edge_if.Ext_Data, 32'h5);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_clear_len", 32'(drained.size()), 32'd1);
        if (drained.size() != 0) begin
            checkOutput("post_clear_first", drained[0], 32'h5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
